ibex_data_mem_responder: RTL

IBEX_DATA_MEM_RESPONDER -- requirements
Module: ibex_data_mem_responder

---
 rtl/ibex_data_mem_responder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ibex_data_mem_responder.sv
// Data-side memory model for an Ibex LSU: byte-lane storage, fixed-latency
// response pipeline, out-of-range error responses with a saturating error count.

module ibex_dmem_lane #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = 10,
  parameter int unsigned VEC_W = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [VEC_W-1:0] wdata_i,
  output logic [VEC_W-1:0] rdata_o
);

  logic [VEC_W-1:0] mem [DEPTH];

  // Read is combinational so a same-cycle write is not visible until the next grant.
  assign rdata_o = mem[idx_i];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[idx_i] <= wdata_i;
  end

endmodule

module ibex_data_mem_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,
  input  logic        stall_i,
  output logic [15:0] err_count_o
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned VEC_W     = 8;
  localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + (33'(MEM_WORDS) << 2);

  logic                              gnt;
  logic                              in_range;
  logic                              wr_ok;
  logic [31:0]                       offset;
  logic [IDX_W-1:0]                  idx;
  logic [NUM_LANES-1:0]              lane_we;
  logic [NUM_LANES-1:0][VEC_W-1:0]   wdata_lanes;
  logic [NUM_LANES-1:0][VEC_W-1:0]   rd_lanes;
  logic                              unused_offset;

  logic [RD_LATENCY:1]               vld_pipe, vld_nxt;
  logic [RD_LATENCY:1]               err_pipe, err_nxt;
  logic [RD_LATENCY:1][31:0]         dat_pipe, dat_nxt;
  logic [15:0]                       err_cnt_q;

  assign gnt        = data_req_i & ~stall_i & ~rst_i;
  assign data_gnt_o = gnt;

  // 33-bit compare so a window touching the top of the address space cannot wrap.
  assign in_range = ({1'b0, data_addr_i} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, data_addr_i} <  END_ADDR);
  assign offset   = data_addr_i - BASE_ADDR;
  assign idx      = offset[IDX_W+1:2];
  assign unused_offset = ^{offset[31:IDX_W+2], offset[1:0]};

  assign wr_ok       = gnt & data_we_i & in_range;
  assign lane_we     = {NUM_LANES{wr_ok}} & data_be_i;
  assign wdata_lanes = data_wdata_i;

  ibex_dmem_lane #(
    .DEPTH (MEM_WORDS),
    .IDX_W (IDX_W),
    .VEC_W (VEC_W)
  ) u_lane [NUM_LANES-1:0] (
    .clk_i   (clk_i),
    .we_i    (lane_we),
    .idx_i   (idx),
    .wdata_i (wdata_lanes),
    .rdata_o (rd_lanes)
  );

  always_comb begin
    vld_nxt    = '0;
    err_nxt    = '0;
    dat_nxt    = '0;
    vld_nxt[1] = gnt;
    err_nxt[1] = gnt & ~in_range;
    dat_nxt[1] = (gnt && !data_we_i && in_range) ? rd_lanes : 32'h0;
    for (int k = 2; k <= int'(RD_LATENCY); k++) begin
      vld_nxt[k] = vld_pipe[k-1];
      err_nxt[k] = err_pipe[k-1];
      dat_nxt[k] = dat_pipe[k-1];
    end
  end

  // Counter bumps on the edge that makes an error response visible, so it
  // reads as already incremented in the response cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_pipe  <= '0;
      err_pipe  <= '0;
      dat_pipe  <= '0;
      err_cnt_q <= '0;
    end else begin
      vld_pipe <= vld_nxt;
      err_pipe <= err_nxt;
      dat_pipe <= dat_nxt;
      if (vld_nxt[RD_LATENCY] && err_nxt[RD_LATENCY] && (err_cnt_q != 16'hFFFF))
        err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign data_rvalid_o     = vld_pipe[RD_LATENCY] & ~rst_i;
  assign data_err_o        = vld_pipe[RD_LATENCY] & err_pipe[RD_LATENCY] & ~rst_i;
  assign data_rdata_o      = (vld_pipe[RD_LATENCY] && !rst_i) ? dat_pipe[RD_LATENCY] : 32'h0;
  assign data_rdata_intg_o = 7'b0;
  assign err_count_o       = rst_i ? 16'h0 : err_cnt_q;

endmodule
